pipeline_hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage 64-bit pipelined core (IF/ID/EX/MEM/WB, branch resolved in ID by comparing register-file operands).
- Detects load-use and branch-operand hazards, then stalls PC and IF/ID while injecting bubbles into ID/EX.
- Squashes the wrong-path instruction after a taken branch.
- Generates EX-stage forwarding selects and keeps saturating stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/hazard_fwd_unit.sv | 68 ++++++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage core hazard controller: FSM states,
// forwarding selects and the register address width.
package pipe_pkg;

    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detector: required stall count for the ID instruction
// and EX-stage operand forwarding selects.
module hazard_fwd_unit #(
    parameter int RA_W = pipe_pkg::RA_W
) (
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_branch,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic            mem_memread,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    output logic [1:0]      stall_need,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b
);
    import pipe_pkg::*;

    logic match_ex;
    logic match_mem;

    // x0 is hardwired zero, so a destination of 0 never creates a dependency.
    function automatic logic id_dep(input logic vld, input logic use1, input logic use2,
                                    input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                                    input logic [RA_W-1:0] rd);
        id_dep = vld && (rd != '0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic mem_we, input logic [RA_W-1:0] m_rd,
                                           input logic wb_we, input logic [RA_W-1:0] w_rd);
        if (mem_we && m_rd != '0 && m_rd == rs)
            fwd_sel = FWD_EXMEM;
        else if (wb_we && w_rd != '0 && w_rd == rs)
            fwd_sel = FWD_MEMWB;
        else
            fwd_sel = FWD_RF;
    endfunction

    always_comb begin
        match_ex  = id_dep(id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2, ex_rd);
        match_mem = id_dep(id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2, mem_rd);

        stall_need = 2'd0;
        if (id_branch) begin
            // Branches compare in ID, so even ALU results in EX must be waited on.
            if (ex_memread && match_ex)
                stall_need = 2'd2;
            else if ((ex_regwrite && match_ex) || (mem_memread && match_mem))
                stall_need = 2'd1;
        end else if (ex_memread && match_ex) begin
            stall_need = 2'd1;
        end

        forward_a = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
        forward_b = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stalls PC and IF/ID, injects ID/EX bubbles,
// squashes the wrong-path fetch after a taken branch, and counts stall/flush cycles.
module pipeline_hazard_ctrl #(
    parameter int RA_W  = pipe_pkg::RA_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_branch,
    input  logic             branch_taken,
    input  logic [RA_W-1:0]  ex_rs1,
    input  logic [RA_W-1:0]  ex_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_regwrite,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);
    import pipe_pkg::*;

    state_e            state_q, state_d;
    logic [1:0]        stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_cycles_q, flush_cycles_d;
    logic [1:0]        stall_need;
    logic [1:0]        fwd_a_raw, fwd_b_raw;

    hazard_fwd_unit #(.RA_W(RA_W)) u_hazard (
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_branch    (id_branch),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .stall_need   (stall_need),
        .forward_a    (fwd_a_raw),
        .forward_b    (fwd_b_raw)
    );

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        forward_a   = fwd_a_raw;
        forward_b   = fwd_b_raw;

        unique case (state_q)
            ST_RUN: begin
                if (stall_need != 2'd0) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (stall_need == 2'd2) begin
                        state_d     = ST_STALL;
                        stall_cnt_d = 2'd1;
                    end
                end else if (id_valid && id_branch && branch_taken) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                stall_cnt_d = stall_cnt_q - 2'd1;
                if (stall_cnt_q <= 2'd1)
                    state_d = ST_RUN;
            end
            ST_FLUSH: begin
                idex_bubble = 1'b1;
                state_d     = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Outputs are held at their benign values while reset is asserted.
        if (!reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
            forward_a   = FWD_RF;
            forward_b   = FWD_RF;
        end

        stall_cycles_d = stall_cycles_q;
        if (!pc_write && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        flush_cycles_d = flush_cycles_q;
        if (state_q == ST_FLUSH && flush_cycles_q != '1)
            flush_cycles_d = flush_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            stall_cnt_q    <= 2'd0;
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign state_o      = state_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;

endmodule
